// File: rtl/alu_seq_pkg.sv
// Types and constants for the ALU operand/opcode sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned FLAG_W   = 3;
    localparam int unsigned NUM_KEYS = 4;

    // Board key indices
    localparam int unsigned KEY_LDA = 0;
    localparam int unsigned KEY_LDB = 1;
    localparam int unsigned KEY_EXE = 2;
    localparam int unsigned KEY_CLR = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        SHOW = 3'd2
    } seq_state_t;

    // Held result payload: ALU value plus {over, zero, neg}
    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [FLAG_W-1:0] flags;
    } seq_result_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types; aluop_t is the opcode the ALU decodes.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'h0,
        ALU_SRL  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_RSVB = 4'hB,
        ALU_RSVC = 4'hC,
        ALU_RSVD = 4'hD,
        ALU_RSVE = 4'hE,
        ALU_RSVF = 4'hF
    } aluop_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes one active-low key and emits a single 1-cycle press pulse
// once the key has been stably low for DEBOUNCE_CYCLES after being stably high.
// Ports: clk_i, rst_ni (async active-low), key_ni (raw key, active-low),
//        press_o (registered press pulse).
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;   // debounced key level (1 = released)
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Stability counter: runs only while the synced key differs from the debounced level
    always_comb begin
        sync_d  = {sync_q[0], key_ni};
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            cnt_d   = '0;
            press_d = ~sync_q[1];         // only the high->low transition is a press
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/alu_operand_seq.sv
// ALU operand/opcode sequencer: debounced keys load sign-extended operands from
// the switches, issue an opcode, and latch the ALU result one settle cycle later.
// Ports: CLK, nRST (async active-low), key_n[3:0] raw keys, sw[17:0] switches,
//        porta/portb/aluop to the ALU, outport/neg/zero/over from the ALU,
//        result/rflags/result_valid held result, a_vld/b_vld operand status,
//        err sticky execute-without-operands flag, state for LEDs.
// Option: ALU_SEQ_ACCUM_CHAIN_EN feeds each result back into porta.
module alu_operand_seq
    import cpu_types_pkg::*;
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned OPW             = 17
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [17:0]         sw,
    output logic [DATA_W-1:0]   porta,
    output logic [DATA_W-1:0]   portb,
    output aluop_t              aluop,
    input  logic [DATA_W-1:0]   outport,
    input  logic                neg,
    input  logic                zero,
    input  logic                over,
    output logic [DATA_W-1:0]   result,
    output logic [FLAG_W-1:0]   rflags,
    output logic                result_valid,
    output logic                a_vld,
    output logic                b_vld,
    output logic                err,
    output logic [2:0]          state
);

    logic [NUM_KEYS-1:0] key_pulse;

    // One debouncer per board key
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i  (CLK),
            .rst_ni (nRST),
            .key_ni (key_n[k]),
            .press_o(key_pulse[k])
        );
    end

    // Prioritised pulse decode: clear > execute > load A > load B
    logic pls_clr_c, pls_exe_c, pls_lda_c, pls_ldb_c;
    assign pls_clr_c = key_pulse[KEY_CLR];
    assign pls_exe_c = key_pulse[KEY_EXE] & ~pls_clr_c;
    assign pls_lda_c = key_pulse[KEY_LDA] & ~pls_clr_c & ~key_pulse[KEY_EXE];
    assign pls_ldb_c = key_pulse[KEY_LDB] & ~pls_clr_c & ~key_pulse[KEY_EXE]
                     & ~key_pulse[KEY_LDA];

    logic [DATA_W-1:0] operand_c;
    assign operand_c = {{(DATA_W - OPW){sw[OPW-1]}}, sw[OPW-1:0]};

    logic sw_unused;
    assign sw_unused = ^sw;

    seq_state_t        state_q, state_d;
    logic [DATA_W-1:0] porta_q, porta_d;
    logic [DATA_W-1:0] portb_q, portb_d;
    aluop_t            aluop_q, aluop_d;
    seq_result_t       res_q, res_d;
    logic              rvld_q, rvld_d;
    logic              a_vld_q, a_vld_d;
    logic              b_vld_q, b_vld_d;
    logic              err_q, err_d;

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        porta_d = porta_q;
        portb_d = portb_q;
        aluop_d = aluop_q;
        res_d   = res_q;
        rvld_d  = rvld_q;
        a_vld_d = a_vld_q;
        b_vld_d = b_vld_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (pls_exe_c) begin
                    if (a_vld_q && b_vld_q) begin
                        aluop_d = aluop_t'(sw[3:0]);
                        err_d   = 1'b0;
                        state_d = EXEC;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (pls_lda_c) begin
                    porta_d = operand_c;
                    a_vld_d = 1'b1;
                end else if (pls_ldb_c) begin
                    portb_d = operand_c;
                    b_vld_d = 1'b1;
                end
            end
            EXEC: begin
                // Settle cycle: ALU output is sampled at the end of it
                res_d.value = outport;
                res_d.flags = {over, zero, neg};
                rvld_d      = 1'b1;
                state_d     = SHOW;
`ifdef ALU_SEQ_ACCUM_CHAIN_EN
                porta_d     = outport;
`endif
            end
            SHOW: begin
                if (pls_exe_c) begin
                    aluop_d = aluop_t'(sw[3:0]);
                    state_d = EXEC;
                end else if (pls_lda_c) begin
                    porta_d = operand_c;
                    a_vld_d = 1'b1;
                    rvld_d  = 1'b0;
                    state_d = IDLE;
                end else if (pls_ldb_c) begin
                    portb_d = operand_c;
                    b_vld_d = 1'b1;
                    rvld_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins everywhere except the single EXEC cycle
        if (pls_clr_c && (state_q != EXEC)) begin
            state_d = IDLE;
            porta_d = '0;
            portb_d = '0;
            aluop_d = aluop_t'(4'h0);
            res_d   = '0;
            rvld_d  = 1'b0;
            a_vld_d = 1'b0;
            b_vld_d = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            porta_q <= '0;
            portb_q <= '0;
            aluop_q <= aluop_t'(4'h0);
            res_q   <= '0;
            rvld_q  <= 1'b0;
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            porta_q <= porta_d;
            portb_q <= portb_d;
            aluop_q <= aluop_d;
            res_q   <= res_d;
            rvld_q  <= rvld_d;
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
            err_q   <= err_d;
        end
    end

    assign porta        = porta_q;
    assign portb        = portb_q;
    assign aluop        = aluop_q;
    assign result       = res_q.value;
    assign rflags       = res_q.flags;
    assign result_valid = rvld_q;
    assign a_vld        = a_vld_q;
    assign b_vld        = b_vld_q;
    assign err          = err_q;
    assign state        = state_q;

endmodule
